mdu_param: RTL and testbench
============================

Name: mdu_param

Overview:
- Parametrised multiply/divide unit for the E stage.
- Replaces the fixed-latency MDU.
- Multiply and divide latencies are configurable, operand width is generic, and the unit has an explicit done pulse and a start-cancel input for interrupt/exception flush.
- Owns the HI/LO registers. Supports signed/unsigned mult/div and mthi/mtlo writes. The hazard unit stalls on Busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MUL_CYCLES, 5, Busy cycles for mult/multu (and madd/msub); must be at least 1.
- DIV_CYCLES, 10, Busy cycles for div/divu; must be at least 1.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- Start  in  1  launch the operation selected by Op; sampled at the rising edge.
- Op  in  3  000 mult, 001 multu, 010 div, 011 divu, 1xx accumulate ops (optional feature).
- D1  in  WIDTH  rs operand; also the mthi/mtlo write data.
- D2  in  WIDTH  rt operand.
- HI_En  in  1  mthi write enable.
- LO_En  in  1  mtlo write enable.
- Cancel  in  1  interrupt/exception flush; suppresses Start in the same cycle.
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse when the result has been committed.
- R_HI  out  WIDTH  HI register.
- R_LO  out  WIDTH  LO register.

Behaviour:
- Reset (Rst=1 at edge): HI=0, LO=0, Busy=0, Done=0, counter=0, state=IDLE. Reset mid-operation aborts it; HI/LO are zeroed and no Done pulse is produced.
- States:
  - IDLE: accepts Start, HI_En, LO_En.
  - RUN: counts down.
- Launch: Start=1 and Cancel=0 in IDLE.
  - Operands and the result are captured at that edge; the result goes into internal staging registers.
  - Counter is loaded with LAT-1, where LAT is MUL_CYCLES or DIV_CYCLES.
  - State becomes RUN and Busy=1 from the next cycle.
- RUN:
  - Counter decrements each edge.
  - At the edge where counter==0, staging is written to HI/LO, state returns to IDLE, and Busy=0.
  - Done=1 for exactly that following cycle, with the new R_HI/R_LO already visible.
  - Busy is high for exactly LAT cycles.
- Start or HI_En/LO_En while Busy: ignored. This never occurs with a correct stall unit; the bench checks that it is harmless.
- Start and HI_En/LO_En in the same IDLE cycle: Start wins and the writes are dropped.
- Cancel=1 with Start: no launch, and Busy stays 0. Cancel also blocks HI_En/LO_En in that cycle. Cancel during RUN is ignored; an in-flight op always completes.
- mthi/mtlo (IDLE, no Start, no Cancel): HI_En loads HI<=D1; LO_En loads LO<=D1. Both may be set at once. Latency is one edge and Done is not pulsed.
- Multiply: full 2*WIDTH product; HI=upper half, LO=lower half. mult treats operands as signed, multu as unsigned.
- Divide: LO=quotient, HI=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed MIN / -1: LO=MIN, HI=0.
  - Divide by zero (D2=0): Busy and Done still behave normally, but HI/LO are unchanged at commit.
- Op 1xx without the optional feature: treated as a no-op launch. Busy runs for MUL_CYCLES, Done pulses, and HI/LO are unchanged.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: Op 100 madd, 101 maddu, 110 msub, 111 msubu are supported, with MUL_CYCLES latency. The result is {HI,LO} ± D1*D2, where the product is signed for madd/msub and unsigned for maddu/msubu. The sum wraps modulo 2^(2*WIDTH). The {HI,LO} value used is the one at the launch edge.
- Undefined: Op 1xx behaves as the no-op launch described above.

Test Plan:
- Reset then mult 0xFFFFFFFF × 0x00000002 (signed) -> Busy high for exactly 5 cycles, Done pulse on cycle 6, HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div -7 / 2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0 with HI=LO=0x12345678 preloaded via mthi/mtlo -> Done pulses, HI/LO still 0x12345678. div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Start+Cancel on a mult -> Busy stays 0, no Done, HI/LO unchanged. Cancel asserted in the 3rd Busy cycle -> op still completes with the correct result.
- Start during Busy, and HI_En during Busy -> both ignored; the first result commits unchanged. Rst asserted in the 4th cycle of a div -> Busy=0, HI=LO=0, no Done.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu 1×1 -> HI=1, LO=0. msub 1×1 from HI=LO=0 -> HI=LO=0xFFFFFFFF. Rerun with MUL_CYCLES=1 and DIV_CYCLES=3 -> Busy widths are 1 and 3.

Source files
------------

// File: rtl/mdu_if.sv
// E-stage <-> MDU bundle: launch/flush controls, operands and mthi/mtlo
// enables from the pipeline, and Busy/Done/HI/LO back from the unit.
interface mdu_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic             HI_En;
    logic             LO_En;
    logic             Cancel;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] R_HI;
    logic [WIDTH-1:0] R_LO;

    modport master (
        output Start, Op, D1, D2, HI_En, LO_En, Cancel,
        input  Busy, Done, R_HI, R_LO
    );

    modport slave (
        input  Start, Op, D1, D2, HI_En, LO_En, Cancel,
        output Busy, Done, R_HI, R_LO
    );
endinterface

// File: rtl/mdu_param.sv
// Parametrised multi-cycle mult/div unit owning HI/LO.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu on Op 1xx.
module mdu_param #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic  Clk,
    input logic  Rst,
    mdu_if.slave bus
);
    localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic               busy, done;
    logic [2*WIDTH-1:0] stage;
    logic               stage_wr;

    logic [WIDTH-1:0]   a, b;
    logic               sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod, hilo;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, b_safe;
    logic [WIDTH-1:0]   q_mag, r_mag, q, r;
    logic [2*WIDTH-1:0] res;
    logic               res_wr;
    logic [CW-1:0]      lat;

    assign a    = bus.D1;
    assign b    = bus.D2;
    assign hilo = {hi, lo};
    // Op bit 0 clear selects the signed flavour of every op
    assign sgn  = ~bus.Op[0];

    always_comb begin
        a_ext = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        prod  = a_ext * b_ext;
    end

    // Magnitude divide, then restore signs; MIN/-1 falls out as MIN rem 0
    always_comb begin
        a_neg  = sgn & a[WIDTH-1];
        b_neg  = sgn & b[WIDTH-1];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        b_safe = (b == '0) ? WIDTH'(1) : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        q      = (a_neg ^ b_neg) ? -q_mag : q_mag;
        r      = a_neg ? -r_mag : r_mag;
    end

    always_comb begin
        res    = hilo;
        res_wr = 1'b0;
        lat    = MUL_LD;
        case (bus.Op[2:1])
            2'b00: begin
                res    = prod;
                res_wr = 1'b1;
            end
            2'b01: begin
                lat = DIV_LD;
                if (b != '0) begin
                    res    = {r, q};
                    res_wr = 1'b1;
                end
            end
            default: begin
`ifdef MDU_MADD_EN
                res    = bus.Op[1] ? hilo - prod : hilo + prod;
                res_wr = 1'b1;
`else
                res_wr = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            stage    <= '0;
            stage_wr <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!bus.Cancel) begin
                        if (bus.Start) begin
                            stage    <= res;
                            stage_wr <= res_wr;
                            cnt      <= lat;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else begin
                            if (bus.HI_En) hi <= bus.D1;
                            if (bus.LO_En) lo <= bus.D1;
                        end
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        if (stage_wr) {hi, lo} <= stage;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.Busy = busy;
    assign bus.Done = done;
    assign bus.R_HI = hi;
    assign bus.R_LO = lo;
endmodule

// File: tb/tb_mdu_param.sv
// Directed bench for mdu_param: latency, results, cancel, reset abort.
// Second instance covers MUL_CYCLES=1 / DIV_CYCLES=3.
module tb_mdu_param;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int tests = 0;
    int fails = 0;

    mdu_if #(.WIDTH(32)) f ();
    mdu_if #(.WIDTH(32)) g ();

    mdu_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk(Clk), .Rst(Rst), .bus(f)
    );
    mdu_param #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut2 (
        .Clk(Clk), .Rst(Rst), .bus(g)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        f.Start = 0; f.Op = 0; f.D1 = 0; f.D2 = 0;
        f.HI_En = 0; f.LO_En = 0; f.Cancel = 0;
        g.Start = 0; g.Op = 0; g.D1 = 0; g.D2 = 0;
        g.HI_En = 0; g.LO_En = 0; g.Cancel = 0;
    endtask

    task automatic write_hilo(input bit he, input bit le, input logic [31:0] d);
        f.HI_En = he; f.LO_En = le; f.D1 = d;
        tick();
        f.HI_En = 0; f.LO_En = 0; f.D1 = 0;
    endtask

    // Launch on dut, optionally poke inputs in given busy cycle (1-based)
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int start_at, input int hien_at,
                          input int rst_at, output int nbusy, output bit done_ok);
        bit early;
        early = 0;
        f.Start = 1; f.Op = op; f.D1 = a; f.D2 = b;
        tick();
        f.Start = 0; f.D1 = 0; f.D2 = 0; f.HI_En = 0; f.LO_En = 0;
        nbusy = 0;
        while (f.Busy && nbusy < 64) begin
            if (f.Done) early = 1;
            nbusy++;
            f.Cancel = (nbusy == cancel_at);
            f.Start  = (nbusy == start_at);
            f.HI_En  = (nbusy == hien_at);
            Rst      = (nbusy == rst_at);
            if (nbusy == start_at) begin f.Op = 0; f.D1 = 5; f.D2 = 5; end
            if (nbusy == hien_at) f.D1 = 32'hDEAD;
            tick();
            f.Cancel = 0; f.Start = 0; f.HI_En = 0; Rst = 0;
            f.D1 = 0; f.D2 = 0;
        end
        done_ok = f.Done && !early;
    endtask

    task automatic test_reset();
        idle_inputs();
        Rst = 1;
        tick(); tick();
        Rst = 0;
        tests++; if (f.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", f.Busy); end
        tests++; if (f.Done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", f.Done); end
        tests++; if (f.R_HI !== 32'h0) begin fails++; $display("FAIL reset_hi got %h want 0", f.R_HI); end
        tests++; if (f.R_LO !== 32'h0) begin fails++; $display("FAIL reset_lo got %h want 0", f.R_LO); end
    endtask

    task automatic test_mult();
        int n; bit d;
        run_op(3'b000, 32'hFFFFFFFF, 32'h2, 0, 0, 0, 0, n, d);
        tests++; if (n !== 5) begin fails++; $display("FAIL mult_busy got %0d want 5", n); end
        tests++; if (d !== 1'b1) begin fails++; $display("FAIL mult_done got %b want 1", d); end
        tests++; if (f.R_HI !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi got %h want ffffffff", f.R_HI); end
        tests++; if (f.R_LO !== 32'hFFFFFFFE) begin fails++; $display("FAIL mult_lo got %h want fffffffe", f.R_LO); end
        tick();
        tests++; if (f.Done !== 1'b0) begin fails++; $display("FAIL done_pulse_width got %b want 0", f.Done); end
    endtask

    task automatic test_multu();
        int n; bit d;
        run_op(3'b001, 32'hFFFFFFFF, 32'h2, 0, 0, 0, 0, n, d);
        tests++; if (d !== 1'b1) begin fails++; $display("FAIL multu_done got %b want 1", d); end
        tests++; if (f.R_HI !== 32'h1) begin fails++; $display("FAIL multu_hi got %h want 00000001", f.R_HI); end
        tests++; if (f.R_LO !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_lo got %h want fffffffe", f.R_LO); end
    endtask

    task automatic test_div();
        int n; bit d;
        run_op(3'b010, 32'hFFFFFFF9, 32'h2, 0, 0, 0, 0, n, d);
        tests++; if (n !== 10) begin fails++; $display("FAIL div_busy got %0d want 10", n); end
        tests++; if (d !== 1'b1) begin fails++; $display("FAIL div_done got %b want 1", d); end
        tests++; if (f.R_LO !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo got %h want fffffffd", f.R_LO); end
        tests++; if (f.R_HI !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi got %h want ffffffff", f.R_HI); end
    endtask

    task automatic test_div_zero();
        int n; bit d;
        write_hilo(1, 1, 32'h12345678);
        tests++; if (f.R_HI !== 32'h12345678) begin fails++; $display("FAIL mthi got %h want 12345678", f.R_HI); end
        tests++; if (f.R_LO !== 32'h12345678) begin fails++; $display("FAIL mtlo got %h want 12345678", f.R_LO); end
        tests++; if (f.Done !== 1'b0) begin fails++; $display("FAIL mtx_done got %b want 0", f.Done); end
        run_op(3'b011, 32'h7, 32'h0, 0, 0, 0, 0, n, d);
        tests++; if (n !== 10) begin fails++; $display("FAIL divz_busy got %0d want 10", n); end
        tests++; if (d !== 1'b1) begin fails++; $display("FAIL divz_done got %b want 1", d); end
        tests++; if (f.R_HI !== 32'h12345678) begin fails++; $display("FAIL divz_hi got %h want 12345678", f.R_HI); end
        tests++; if (f.R_LO !== 32'h12345678) begin fails++; $display("FAIL divz_lo got %h want 12345678", f.R_LO); end
    endtask

    task automatic test_div_ovf();
        int n; bit d;
        run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, n, d);
        tests++; if (f.R_LO !== 32'h80000000) begin fails++; $display("FAIL ovf_lo got %h want 80000000", f.R_LO); end
        tests++; if (f.R_HI !== 32'h0) begin fails++; $display("FAIL ovf_hi got %h want 0", f.R_HI); end
    endtask

    task automatic test_cancel();
        int seen;
        f.Start = 1; f.Cancel = 1; f.Op = 0; f.D1 = 3; f.D2 = 4;
        f.HI_En = 1; f.LO_En = 1;
        tick();
        idle_inputs();
        tests++; if (f.Busy !== 1'b0) begin fails++; $display("FAIL cancel_busy got %b want 0", f.Busy); end
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            if (f.Busy || f.Done) seen++;
            tick();
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL cancel_activity got %0d want 0", seen); end
        tests++; if (f.R_HI !== 32'h0) begin fails++; $display("FAIL cancel_hi got %h want 0", f.R_HI); end
        tests++; if (f.R_LO !== 32'h80000000) begin fails++; $display("FAIL cancel_lo got %h want 80000000", f.R_LO); end
    endtask

    task automatic test_cancel_run();
        int n; bit d;
        run_op(3'b000, 32'h3, 32'h4, 3, 0, 0, 0, n, d);
        tests++; if (n !== 5) begin fails++; $display("FAIL cancel_run_busy got %0d want 5", n); end
        tests++; if (d !== 1'b1) begin fails++; $display("FAIL cancel_run_done got %b want 1", d); end
        tests++; if (f.R_LO !== 32'd12) begin fails++; $display("FAIL cancel_run_lo got %h want 0000000c", f.R_LO); end
    endtask

    task automatic test_busy_ignore();
        int n; bit d;
        run_op(3'b001, 32'd6, 32'd7, 0, 2, 3, 0, n, d);
        tests++; if (n !== 5) begin fails++; $display("FAIL ignore_busy got %0d want 5", n); end
        tests++; if (f.R_LO !== 32'd42) begin fails++; $display("FAIL ignore_lo got %h want 0000002a", f.R_LO); end
        tests++; if (f.R_HI !== 32'h0) begin fails++; $display("FAIL ignore_hi got %h want 0", f.R_HI); end
        tick();
        tests++; if (f.Busy !== 1'b0) begin fails++; $display("FAIL ignore_relaunch got %b want 0", f.Busy); end
    endtask

    task automatic test_start_wins();
        int n; bit d;
        f.HI_En = 1; f.LO_En = 1;
        run_op(3'b001, 32'd3, 32'd4, 0, 0, 0, 0, n, d);
        tests++; if (f.R_HI !== 32'h0) begin fails++; $display("FAIL start_wins_hi got %h want 0", f.R_HI); end
        tests++; if (f.R_LO !== 32'd12) begin fails++; $display("FAIL start_wins_lo got %h want 0000000c", f.R_LO); end
    endtask

    task automatic test_reset_mid();
        int n; bit d;
        run_op(3'b010, 32'd100, 32'd7, 0, 0, 0, 4, n, d);
        tests++; if (n !== 4) begin fails++; $display("FAIL rst_mid_cycles got %0d want 4", n); end
        tests++; if (d !== 1'b0) begin fails++; $display("FAIL rst_mid_done got %b want 0", d); end
        tests++; if (f.R_HI !== 32'h0) begin fails++; $display("FAIL rst_mid_hi got %h want 0", f.R_HI); end
        tests++; if (f.R_LO !== 32'h0) begin fails++; $display("FAIL rst_mid_lo got %h want 0", f.R_LO); end
        tick();
        tests++; if (f.Done !== 1'b0) begin fails++; $display("FAIL rst_mid_late_done got %b want 0", f.Done); end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        int n; bit d;
        write_hilo(1, 0, 32'h0);
        write_hilo(0, 1, 32'hFFFFFFFF);
        run_op(3'b101, 32'd1, 32'd1, 0, 0, 0, 0, n, d);
        tests++; if (n !== 5) begin fails++; $display("FAIL maddu_busy got %0d want 5", n); end
        tests++; if (f.R_HI !== 32'h1) begin fails++; $display("FAIL maddu_hi got %h want 00000001", f.R_HI); end
        tests++; if (f.R_LO !== 32'h0) begin fails++; $display("FAIL maddu_lo got %h want 0", f.R_LO); end
        write_hilo(1, 1, 32'h0);
        run_op(3'b110, 32'd1, 32'd1, 0, 0, 0, 0, n, d);
        tests++; if (f.R_HI !== 32'hFFFFFFFF) begin fails++; $display("FAIL msub_hi got %h want ffffffff", f.R_HI); end
        tests++; if (f.R_LO !== 32'hFFFFFFFF) begin fails++; $display("FAIL msub_lo got %h want ffffffff", f.R_LO); end
    endtask
`else
    task automatic test_noop();
        int n; bit d;
        write_hilo(1, 0, 32'hAAAA5555);
        write_hilo(0, 1, 32'h5555AAAA);
        run_op(3'b100, 32'd3, 32'd4, 0, 0, 0, 0, n, d);
        tests++; if (n !== 5) begin fails++; $display("FAIL noop_busy got %0d want 5", n); end
        tests++; if (d !== 1'b1) begin fails++; $display("FAIL noop_done got %b want 1", d); end
        tests++; if (f.R_HI !== 32'hAAAA5555) begin fails++; $display("FAIL noop_hi got %h want aaaa5555", f.R_HI); end
        tests++; if (f.R_LO !== 32'h5555AAAA) begin fails++; $display("FAIL noop_lo got %h want 5555aaaa", f.R_LO); end
    endtask
`endif

    task automatic test_latency();
        int n;
        g.Start = 1; g.Op = 3'b000; g.D1 = 3; g.D2 = 4;
        tick();
        g.Start = 0; g.D1 = 0; g.D2 = 0;
        n = 0;
        while (g.Busy && n < 64) begin n++; tick(); end
        tests++; if (n !== 1) begin fails++; $display("FAIL lat_mul_busy got %0d want 1", n); end
        tests++; if (g.Done !== 1'b1) begin fails++; $display("FAIL lat_mul_done got %b want 1", g.Done); end
        tests++; if (g.R_LO !== 32'd12) begin fails++; $display("FAIL lat_mul_lo got %h want 0000000c", g.R_LO); end
        g.Start = 1; g.Op = 3'b011; g.D1 = 9; g.D2 = 3;
        tick();
        g.Start = 0; g.D1 = 0; g.D2 = 0;
        n = 0;
        while (g.Busy && n < 64) begin n++; tick(); end
        tests++; if (n !== 3) begin fails++; $display("FAIL lat_div_busy got %0d want 3", n); end
        tests++; if (g.R_LO !== 32'd3) begin fails++; $display("FAIL lat_div_lo got %h want 00000003", g.R_LO); end
        tests++; if (g.R_HI !== 32'd0) begin fails++; $display("FAIL lat_div_hi got %h want 0", g.R_HI); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_div_ovf();
        test_cancel();
        test_cancel_run();
        test_busy_ignore();
        test_start_wins();
        test_reset_mid();
`ifdef MDU_MADD_EN
        test_madd();
`else
        test_noop();
`endif
        test_latency();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
